seg_entry_scan_ctrl: RTL

- Controller for the 6-digit seven-segment entry display driven by the 4-line keypad.
- Debounces keypad lines and decodes keys into digit, backspace or clear commands, then sequences the 6-entry digit buffer.
- Time-multiplexes the digit buffer onto scan/dout with per-digit dwell and an anti-ghosting blank interval.
- Sits between the keypad pins and the display pins; replaces free-running scan and key logic with one reset-clean controller.

---
 rtl/seg_pkg.sv | 56 +++++
 rtl/key_debounce.sv | 83 ++++++++
 rtl/seg_entry_scan_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - keypad codes, segment patterns and key decode for the entry display
// Shared by key_debounce and seg_entry_scan_ctrl. No ports.
package seg_pkg;

    localparam logic [3:0] KEY_1    = 4'b1110;
    localparam logic [3:0] KEY_2    = 4'b1101;
    localparam logic [3:0] KEY_3    = 4'b1011;
    localparam logic [3:0] KEY_4    = 4'b0111;
    localparam logic [3:0] KEY_5    = 4'b1100;
    localparam logic [3:0] KEY_6    = 4'b1010;
    localparam logic [3:0] KEY_7    = 4'b0110;
    localparam logic [3:0] KEY_8    = 4'b1001;
    localparam logic [3:0] KEY_BS   = 4'b0011;
    localparam logic [3:0] KEY_CLR  = 4'b0101;
    localparam logic [3:0] KEY_NONE = 4'b1111;

    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;

    typedef enum logic [1:0] {CMD_IGNORE, CMD_DIGIT, CMD_BS, CMD_CLR} cmd_e;

    typedef struct packed {
        cmd_e       cmd;
        logic [7:0] seg;
    } key_cmd_t;

    typedef enum logic [1:0] {KS_IDLE, KS_DEB_PRESS, KS_HELD, KS_DEB_REL} key_state_e;
    typedef enum logic {SS_BLANK, SS_ACTIVE} scan_state_e;

    function automatic key_cmd_t key_to_seg(input logic [3:0] code);
        key_cmd_t r;
        r.cmd = CMD_DIGIT;
        r.seg = 8'h00;
        case (code)
            KEY_1:   r.seg = SEG_1;
            KEY_2:   r.seg = SEG_2;
            KEY_3:   r.seg = SEG_3;
            KEY_4:   r.seg = SEG_4;
            KEY_5:   r.seg = SEG_5;
            KEY_6:   r.seg = SEG_6;
            KEY_7:   r.seg = SEG_7;
            KEY_8:   r.seg = SEG_8;
            KEY_BS:  r.cmd = CMD_BS;
            KEY_CLR: r.cmd = CMD_CLR;
            default: r.cmd = CMD_IGNORE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - press/release debouncer for the 4-line active-low keypad
// Ports: clk100khz, rst (sync, active-high), din[3:0] keypad lines,
//        press_valid one-cycle pulse on an accepted press, press_code stable code.
module key_debounce
    import seg_pkg::*;
#(
    parameter int unsigned DEB = 15000
) (
    input  logic       clk100khz,
    input  logic       rst,
    input  logic [3:0] din,
    output logic       press_valid,
    output logic [3:0] press_code
);

    localparam int unsigned CW = $clog2(DEB + 1);

    key_state_e    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;

    // cnt_q counts consecutive identical samples; the sample that makes it
    // DEB is the one that accepts the press or release.
    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        press_valid = 1'b0;
        case (st_q)
            KS_IDLE: begin
                if (din != KEY_NONE) begin
                    st_d   = KS_DEB_PRESS;
                    code_d = din;
                    cnt_d  = CW'(1);
                end
            end
            KS_DEB_PRESS: begin
                if (din == KEY_NONE) begin
                    st_d = KS_IDLE;
                end else if (din != code_q) begin
                    code_d = din;
                    cnt_d  = CW'(1);
                end else if (cnt_q == CW'(DEB - 1)) begin
                    st_d        = KS_HELD;
                    press_valid = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            KS_HELD: begin
                if (din == KEY_NONE) begin
                    st_d  = KS_DEB_REL;
                    cnt_d = CW'(1);
                end
            end
            KS_DEB_REL: begin
                if (din != KEY_NONE) begin
                    st_d = KS_HELD;
                end else if (cnt_q == CW'(DEB - 1)) begin
                    st_d = KS_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: st_d = KS_IDLE;
        endcase
    end

    always_ff @(posedge clk100khz) begin
        if (rst) begin
            st_q   <= KS_IDLE;
            cnt_q  <= '0;
            code_q <= KEY_NONE;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            code_q <= code_d;
        end
    end

    assign press_code = code_q;

endmodule

// File: rtl/seg_entry_scan_ctrl.sv
// rtl/seg_entry_scan_ctrl.sv - keypad entry buffer and 6-digit seven-segment scan controller
// Ports: clk100khz, rst (sync, active-high), din[3:0] keypad lines (active-low),
//        scan[5:0] one-hot digit enable (bit0 = newest), dout[7:0] segments,
//        key_evt one-cycle command pulse, full while 6 digits are held.
module seg_entry_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DEB   = 15000,
    parameter int unsigned DWELL = 100,
    parameter int unsigned BLANK = 4
) (
    input  logic       clk100khz,
    input  logic       rst,
    input  logic [3:0] din,
    output logic [5:0] scan,
    output logic [7:0] dout,
    output logic       key_evt,
    output logic       full
);

    localparam int unsigned DMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned DW   = (DMAX > 1) ? $clog2(DMAX) : 1;

    logic       press_valid;
    logic [3:0] press_code;

    key_debounce #(.DEB(DEB)) u_key_debounce (
        .clk100khz   (clk100khz),
        .rst         (rst),
        .din         (din),
        .press_valid (press_valid),
        .press_code  (press_code)
    );

    // led_q[0] is led1 (newest entry), led_q[5] is led6.
    logic [5:0][7:0] led_q, led_d;
    logic [2:0]      count_q, count_d;
    logic            key_evt_q, key_evt_d;
    logic            full_q, full_d;
    key_cmd_t        kc;

    always_comb begin
        led_d     = led_q;
        count_d   = count_q;
        key_evt_d = 1'b0;
        kc        = key_to_seg(press_code);
        if (press_valid) begin
            case (kc.cmd)
                CMD_DIGIT: begin
                    if (count_q < 3'd6) begin
                        led_d     = {led_q[4:0], kc.seg};
                        count_d   = count_q + 3'd1;
                        key_evt_d = 1'b1;
                    end
                end
                CMD_BS: begin
                    if (count_q != 3'd0) begin
                        led_d     = {8'h00, led_q[5:1]};
                        count_d   = count_q - 3'd1;
                        key_evt_d = 1'b1;
                    end
                end
                CMD_CLR: begin
                    led_d     = '0;
                    count_d   = 3'd0;
                    key_evt_d = 1'b1;
                end
                default: ;
            endcase
        end
        full_d = (count_d == 3'd6);
    end

    scan_state_e   ss_q, ss_d;
    logic [2:0]    idx_q, idx_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [5:0]    scan_q, scan_d;
    logic [7:0]    dout_q, dout_d;

    // Outputs are registered from the current scan state and buffer, so a
    // buffer write reaches dout one cycle after it lands in led_q.
    always_comb begin
        ss_d   = ss_q;
        idx_d  = idx_q;
        dcnt_d = dcnt_q + DW'(1);
        case (ss_q)
            SS_BLANK: begin
                if (dcnt_q == DW'(BLANK - 1)) begin
                    ss_d   = SS_ACTIVE;
                    dcnt_d = '0;
                end
            end
            SS_ACTIVE: begin
                if (dcnt_q == DW'(DWELL - 1)) begin
                    ss_d   = SS_BLANK;
                    dcnt_d = '0;
                    idx_d  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                end
            end
            default: ss_d = SS_BLANK;
        endcase
        scan_d = 6'd0;
        dout_d = 8'h00;
        if (ss_q == SS_ACTIVE) begin
            scan_d = 6'd1 << idx_q;
            dout_d = led_q[idx_q];
        end
    end

    always_ff @(posedge clk100khz) begin
        if (rst) begin
            led_q     <= '0;
            count_q   <= 3'd0;
            key_evt_q <= 1'b0;
            full_q    <= 1'b0;
            ss_q      <= SS_BLANK;
            idx_q     <= 3'd0;
            dcnt_q    <= '0;
            scan_q    <= 6'd0;
            dout_q    <= 8'h00;
        end else begin
            led_q     <= led_d;
            count_q   <= count_d;
            key_evt_q <= key_evt_d;
            full_q    <= full_d;
            ss_q      <= ss_d;
            idx_q     <= idx_d;
            dcnt_q    <= dcnt_d;
            scan_q    <= scan_d;
            dout_q    <= dout_d;
        end
    end

    assign scan    = scan_q;
    assign dout    = dout_q;
    assign key_evt = key_evt_q;
    assign full    = full_q;

endmodule
